// File: rtl/sram_prog_loader.sv
// Byte-serial SRAM programming sequencer: takes whole synaptic (32-bit) or
// neuron (128-bit) words over valid/ready and replays them as SETUP/WRITE
// byte pairs on the synaptic/neuron core programming ports.
module sram_prog_loader #(
    parameter int unsigned N = 256,
    parameter int unsigned M = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD_EN,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic                IN_IS_NEUR,
    input  logic [2*M-4:0]      IN_ADDR,
    input  logic [127:0]        IN_DATA,
    output logic                CTRL_SYNARRAY_CS,
    output logic                CTRL_SYNARRAY_WE,
    output logic [2*M-4:0]      CTRL_SYNARRAY_ADDR,
    output logic                CTRL_NEURMEM_CS,
    output logic                CTRL_NEURMEM_WE,
    output logic [M-1:0]        CTRL_NEURMEM_ADDR,
    output logic [2*M-1:0]      CTRL_PROG_DATA,
    output logic [2*M-1:0]      CTRL_SPI_ADDR,
    output logic                SPI_GATE_ACTIVITY_sync,
    output logic                BUSY,
    output logic [15:0]         WORD_CNT,
    output logic                ERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StWrite} state_e;

    state_e          state_q;
    logic            neur_q;
    logic [3:0]      k_q;
    logic [119:0]    data_q;     // bytes still to be sent after the current one
    logic            busy_q;
    logic [15:0]     cnt_q;
    logic            err_q;
    logic            gate_q;
    logic            syn_cs_q, syn_we_q, neur_cs_q, neur_we_q;
    logic [2*M-4:0]  syn_addr_q;
    logic [M-1:0]    neur_addr_q;
    logic [2*M-1:0]  prog_q, spi_q;

    logic out_of_range;
    logic last_byte;

    // Neuron rows beyond N cannot exist; such words are swallowed and flagged.
    assign out_of_range = IN_IS_NEUR && (32'(IN_ADDR) >= N);
    assign last_byte    = neur_q ? (k_q == 4'd15) : (k_q == 4'd3);

    // Byte index placement: synaptic index in [14:13], neuron index in [11:8].
    function automatic logic [2*M-1:0] spi_sel(input logic neur, input logic [3:0] k);
        logic [2*M-1:0] s;
        s = '0;
        if (neur) s[11:8] = k;
        else      s[14:13] = k[1:0];
        return s;
    endfunction

    // Sequencer FSM with all core-facing outputs registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            neur_q      <= 1'b0;
            k_q         <= 4'd0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= 16'd0;
            err_q       <= 1'b0;
            syn_cs_q    <= 1'b0;
            syn_we_q    <= 1'b0;
            syn_addr_q  <= '0;
            neur_cs_q   <= 1'b0;
            neur_we_q   <= 1'b0;
            neur_addr_q <= '0;
            prog_q      <= '0;
            spi_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        if (out_of_range) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= StSetup;
                            busy_q      <= 1'b1;
                            neur_q      <= IN_IS_NEUR;
                            k_q         <= 4'd0;
                            data_q      <= IN_DATA[127:8];
                            syn_cs_q    <= !IN_IS_NEUR;
                            syn_addr_q  <= IN_IS_NEUR ? '0 : IN_ADDR;
                            neur_cs_q   <= IN_IS_NEUR;
                            neur_addr_q <= IN_IS_NEUR ? IN_ADDR[M-1:0] : '0;
                            prog_q      <= {{(2*M-8){1'b0}}, IN_DATA[7:0]};
                            spi_q       <= spi_sel(IN_IS_NEUR, 4'd0);
                        end
                    end
                end
                StSetup: begin
                    state_q   <= StWrite;
                    syn_we_q  <= !neur_q;
                    neur_we_q <= neur_q;
                end
                StWrite: begin
                    syn_we_q  <= 1'b0;
                    neur_we_q <= 1'b0;
                    if (last_byte) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cnt_q       <= cnt_q + 16'd1;
                        syn_cs_q    <= 1'b0;
                        syn_addr_q  <= '0;
                        neur_cs_q   <= 1'b0;
                        neur_addr_q <= '0;
                        prog_q      <= '0;
                        spi_q       <= '0;
                    end else begin
                        state_q <= StSetup;
                        k_q     <= k_q + 4'd1;
                        data_q  <= {8'b0, data_q[119:8]};
                        prog_q  <= {{(2*M-8){1'b0}}, data_q[7:0]};
                        spi_q   <= spi_sel(neur_q, k_q + 4'd1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Activity gate follows the previous cycle's session/busy status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) gate_q <= 1'b0;
        else     gate_q <= LOAD_EN | busy_q;
    end

    // Held low while reset is asserted so every output reads 0 in reset.
    assign IN_READY               = !RST && (state_q == StIdle);
    assign BUSY                   = busy_q;
    assign WORD_CNT               = cnt_q;
    assign ERR                    = err_q;
    assign SPI_GATE_ACTIVITY_sync = gate_q;
    assign CTRL_SYNARRAY_CS       = syn_cs_q;
    assign CTRL_SYNARRAY_WE       = syn_we_q;
    assign CTRL_SYNARRAY_ADDR     = syn_addr_q;
    assign CTRL_NEURMEM_CS        = neur_cs_q;
    assign CTRL_NEURMEM_WE        = neur_we_q;
    assign CTRL_NEURMEM_ADDR      = neur_addr_q;
    assign CTRL_PROG_DATA         = prog_q;
    assign CTRL_SPI_ADDR          = spi_q;

endmodule
